// File: rtl/prog_clock_divider.sv
// Programmable divider/tick generator: a divisor written through a shadow register takes effect only at a wrap or restart.
// All outputs are registered, so no input reaches an output combinationally; pause holds the whole count state.
module prog_clock_divider #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 1000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             div_we_i,
  input  logic [CNT_W-1:0] div_in_i,
  input  logic             mode_i,
  output logic             cout_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] div_cur_o,
  output logic             div_err_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             at_end;
  logic             wrap;
  logic             apply;
  logic             wr_ok;

  assign at_end = (count_q == div_q - CNT_W'(1));
  assign wrap   = en_i && !clr_i && at_end;
  assign apply  = clr_i || wrap;
  assign wr_ok  = div_we_i && (div_in_i >= CNT_W'(2));

  always_comb begin
    count_d  = count_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = tick_q;
    cout_d   = cout_q;
    err_d    = 1'b0;

    // Apply uses the shadow value from before this edge; a write on the same edge stays pending.
    if (apply) begin
      if (pend_q) begin
        div_d = shadow_q;
      end
      pend_d = 1'b0;
    end

    if (div_we_i) begin
      if (wr_ok) begin
        shadow_d = div_in_i;
        pend_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (clr_i) begin
      count_d = '0;
      tick_d  = 1'b0;
      cout_d  = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
        tick_d  = 1'b0;
      end
      cout_d = mode_i ? (count_d >= (div_d >> 1)) : tick_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      div_q    <= CNT_W'(DIV_DEFAULT);
      shadow_q <= CNT_W'(DIV_DEFAULT);
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  assign count_o   = count_q;
  assign div_cur_o = div_q;
  assign tick_o    = tick_q;
  assign cout_o    = cout_q;
  assign div_err_o = err_q;

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Parametrised, run-time programmable clock divider and tick generator. Successor to the fixed 1 kHz to 1 Hz divider. Adds:
- programmable divisor, loaded through a shadow register,
- pulse and square-wave output modes,
- enable/pause and synchronous restart,
- asynchronous active-low reset.

It sits between the board clock and the timekeeping, display-scan and blink logic. One instance is used per required rate.

Parameters:
CNT_W, 16, width of the counter and divisor registers.
DIV_DEFAULT, 1000, divisor loaded at reset; must satisfy 2 <= DIV_DEFAULT <= 2^CNT_W-1.

Ports:
Clk  in  1  system clock; all state updates on posedge.
Rst  in  1  asynchronous, active-low reset.
En  in  1  count enable; 0 = pause (all state holds).
Clr  in  1  synchronous restart of the current period.
Div_We  in  1  write strobe for Div_In.
Div_In  in  CNT_W  requested divisor.
Mode  in  1  0 = Cout is a one-cycle pulse; 1 = Cout is a square wave.
Cout  out  1  divided output (registered).
Tick  out  1  one-Clk-cycle pulse per period, independent of Mode (registered).
Count  out  CNT_W  current counter value, range 0..D-1.
Div_Cur  out  CNT_W  active divisor D.
Div_Err  out  1  one-cycle pulse: the last Div_We was rejected.

Behaviour:
- Reset (Rst=0, asynchronous, no Clk needed):
  - Count=0, Cout=0, Tick=0, Div_Err=0.
  - D=DIV_DEFAULT; pending flag P=0.
  - Holds while Rst=0; normal operation from the first posedge after release.
- Registers:
  - Active divisor D (shown on Div_Cur).
  - Shadow divisor S and pending flag P.
- Divisor write, on a posedge with Div_We=1:
  - Div_In < 2: S and P unchanged; Div_Err=1 for the next cycle.
  - Otherwise: S<=Div_In, P<=1, Div_Err<=0.
  - A second valid write before the value is applied overwrites S (last write wins).
- Divisor apply: D<=S and P<=0 only at a wrap edge or a Clr edge, so D never changes mid-period. A Div_We in the same cycle as a wrap or Clr does not apply until the next wrap or Clr; the old S, if pending, applies on that edge.
- Priority per posedge: Clr > En.
- Clr=1 (regardless of En):
  - Count<=0, Tick<=0, Cout<=0.
  - Pending divisor applied.
- En=0 and Clr=0: Count, Cout and Tick hold. Tick therefore stays high if the pause begins right after a wrap. Div_We is still accepted.
- En=1 and Clr=0:
  - Count==D-1 (wrap): Count<=0, Tick<=1, pending divisor applied.
  - Otherwise: Count<=Count+1, Tick<=0.
- Tick timing: high exactly 1 cycle every D enabled cycles, the cycle after Count==D-1.
- Cout, updated on the same edge as Count:
  - Mode 0: Cout<=next Tick value.
  - Mode 1: Cout<=(next Count >= D_next>>1).
  - Result in Mode 1: low for floor(D/2) cycles, high for ceil(D/2) cycles, period D. D odd gives the extra cycle high; D=2 toggles every cycle.
  - Mode changes take effect at the next posedge; no glitch-free requirement on the transition period.
- Arithmetic:
  - All compares are unsigned, CNT_W bits.
  - Count never exceeds D-1, because D only changes when Count becomes 0.
  - Count+1 cannot overflow.
- Reset mid-period: all state returns to reset values immediately. A pending divisor is lost.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then En=1, Mode=0, default D=1000 → Tick/Cout high 1 cycle at cycle 1000 after release, then every 1000 cycles; Count sequence 0..999,0.
2. Div_In=5 written while Count=300 (D=1000) → Div_Cur stays 1000 until wrap; then Tick period 5; Mode=1 gives Cout pattern 0,0,1,1,1 repeating.
3. Div_In=1, then Div_In=0 → Div_Err pulses 1 cycle each; Div_Cur and the period unchanged.
4. En=0 for 7 cycles at Count=2 (D=5) → Count/Cout/Tick frozen; after En=1 the next Tick is 3 enabled cycles later.
5. Clr at Count=3 with pending S=4 → next cycle Count=0, Cout=0, Div_Cur=4; Tick 4 cycles later. Clr together with En=0 still clears.
6. Rst low for less than 1 Clk period at Count=500 → outputs zero asynchronously; D=1000; counting restarts from 0.
